// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add controller for MULT/MULTU. One multiply in
// flight at a time; the HI/LO product registers are written only when it completes.
module mult_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             sgn_i,
   input  logic [WIDTH-1:0] srca_i,
   input  logic [WIDTH-1:0] srcb_i,
   output logic             busy_o,
   output logic             prodv_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   mc_q, mc_d;
   logic [WIDTH-1:0]   mp_q, mp_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               prodv_q, prodv_d;
   logic               done_q, done_d;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // prodv resets high so a read of HI/LO straight after reset never stalls forever.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mc_q    <= '0;
         mp_q    <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         prodv_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         prodv_q <= prodv_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mc_d    = mc_q;
      mp_d    = mp_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      prodv_d = prodv_q;
      done_d  = 1'b0;
      sum     = '0;
      prod    = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               // Signed operands run as magnitudes; the sign is reapplied in FIX.
               mc_d    = (sgn_i & srca_i[WIDTH-1]) ? -srca_i : srca_i;
               mp_d    = (sgn_i & srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;
               neg_d   = sgn_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               prodv_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum   = acc_q + (mp_q[0] ? {1'b0, mc_q} : '0);
            acc_d = {1'b0, sum[WIDTH:1]};
            mp_d  = {sum[0], mp_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            prod = {acc_q[WIDTH-1:0], mp_q};
            if (neg_q) begin
               prod = -prod;
            end
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
            prodv_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o  = (state_q != IDLE);
   assign prodv_o = prodv_q;
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and corner-case bench for mult_sequencer: latency, sign handling,
// busy/back-to-back behaviour and asynchronous reset during a multiply.
module tb_mult_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        sgn;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        busy;
   logic        prodv;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mult_sequencer #(.WIDTH(32), .CNTW(6)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .start_i (start),
      .sgn_i   (sgn),
      .srca_i  (srca),
      .srcb_i  (srcb),
      .busy_o  (busy),
      .prodv_o (prodv),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one multiply and reports how many edges after acceptance done
   // appeared (-1 on timeout) and whether hi/lo/prodv held still meanwhile.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output logic prodvAcc, output logic stable);
      logic [31:0] h0;
      logic [31:0] l0;
      h0 = hi;
      l0 = lo;
      start = 1'b1;
      sgn   = s;
      srca  = a;
      srcb  = b;
      tick();
      start = 1'b0;
      srca  = $urandom;
      srcb  = $urandom;
      prodvAcc = prodv;
      stable   = 1'b1;
      lat      = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (hi !== h0 || lo !== l0 || prodv !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      sgn   = 1'b0;
      srca  = 32'd3;
      srcb  = 32'd3;
      repeat (2) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      checks++; if (prodv !== 1'b1) begin errors++; $display("[TB] FAIL reset_prodv got %b expected 1", prodv); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
      checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h expected 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h expected 0", lo); end
      start = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_multu_max();
      int lat;
      logic pa, st;
      run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, pa, st);
      checks++; if (pa !== 1'b0) begin errors++; $display("[TB] FAIL multu_prodv_accept got %b expected 0", pa); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL multu_run_stable got %b expected 1", st); end
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL multu_latency got %0d expected 33", lat); end
      checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi got %h expected fffffffe", hi); end
      checks++; if (lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo got %h expected 00000001", lo); end
      checks++; if (prodv !== 1'b1) begin errors++; $display("[TB] FAIL multu_prodv_done got %b expected 1", prodv); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_width got %b expected 0", done); end
      checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin errors++; $display("[TB] FAIL multu_hold got %h_%h expected fffffffe_00000001", hi, lo); end
   endtask

   task automatic test_signed();
      int lat;
      logic pa, st;
      run_mult(32'd7, 32'hFFFFFFFD, 1'b1, lat, pa, st);
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_7_m3 got %h_%h expected ffffffff_ffffffeb", hi, lo); end
      tick();
      run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, pa, st);
      checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("[TB] FAIL mult_m1_m1 got %h_%h expected 00000000_00000001", hi, lo); end
      tick();
      run_mult(32'h80000000, 32'h80000000, 1'b1, lat, pa, st);
      checks++; if (hi !== 32'h40000000 || lo !== 32'h0) begin errors++; $display("[TB] FAIL mult_min_min got %h_%h expected 40000000_00000000", hi, lo); end
      tick();
      run_mult(32'h80000000, 32'h80000000, 1'b0, lat, pa, st);
      checks++; if (hi !== 32'h40000000 || lo !== 32'h0) begin errors++; $display("[TB] FAIL multu_min_min got %h_%h expected 40000000_00000000", hi, lo); end
      tick();
      run_mult(32'h80000000, 32'd1, 1'b1, lat, pa, st);
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'h80000000) begin errors++; $display("[TB] FAIL mult_min_1 got %h_%h expected ffffffff_80000000", hi, lo); end
      tick();
   endtask

   task automatic test_busy_ignore();
      int lat;
      logic busyAt10;
      start = 1'b1;
      sgn   = 1'b0;
      srca  = 32'd3;
      srcb  = 32'd5;
      tick();
      start    = 1'b0;
      lat      = -1;
      busyAt10 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         start = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (k == 10) begin
            busyAt10 = busy;
            start = 1'b1;
            srca  = 32'd9;
            srcb  = 32'd9;
         end
      end
      checks++; if (busyAt10 !== 1'b1) begin errors++; $display("[TB] FAIL busy_run got %b expected 1", busyAt10); end
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL busy_latency got %0d expected 33", lat); end
      checks++; if (hi !== 32'h0 || lo !== 32'd15) begin errors++; $display("[TB] FAIL busy_result got %h_%h expected 00000000_0000000f", hi, lo); end
   endtask

   // Called while done is still high from the previous multiply.
   task automatic test_back_to_back();
      int lat;
      logic pa, st;
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_before got %b expected 1", done); end
      run_mult(32'd2, 32'd4, 1'b0, lat, pa, st);
      checks++; if (pa !== 1'b0) begin errors++; $display("[TB] FAIL b2b_prodv_accept got %b expected 0", pa); end
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected 33", lat); end
      checks++; if (hi !== 32'h0 || lo !== 32'd8) begin errors++; $display("[TB] FAIL b2b_result got %h_%h expected 00000000_00000008", hi, lo); end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      logic pa, st;
      logic doneSeen;
      logic hiloMoved;
      run_mult(32'd3, 32'd3, 1'b0, lat, pa, st);
      tick();
      start = 1'b1;
      sgn   = 1'b0;
      srca  = 32'h1234;
      srcb  = 32'h5678;
      tick();
      start = 1'b0;
      repeat (12) tick();
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b expected 0", busy); end
      checks++; if (prodv !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_prodv got %b expected 1", prodv); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_hilo got %h_%h expected 00000000_00000000", hi, lo); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b expected 0", done); end
      #1 reset = 1'b0;
      doneSeen  = 1'b0;
      hiloMoved = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done !== 1'b0) doneSeen = 1'b1;
         if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) hiloMoved = 1'b1;
      end
      checks++; if (doneSeen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_done got %b expected 0", doneSeen); end
      checks++; if (hiloMoved !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_quiet got %b expected 0", hiloMoved); end
      run_mult(32'h1234, 32'h5678, 1'b0, lat, pa, st);
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL rstmid_restart_latency got %0d expected 33", lat); end
      checks++; if (hi !== 32'h0 || lo !== 32'h06260060) begin errors++; $display("[TB] FAIL rstmid_restart got %h_%h expected 00000000_06260060", hi, lo); end
      tick();
   endtask

   task automatic test_regression();
      logic [31:0] corner [5];
      logic [31:0] a, b;
      logic        s;
      logic [63:0] ea, eb, expProd;
      int lat;
      logic pa, st;
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
      for (int n = 0; n < 200; n++) begin
         if (n < 50) begin
            a = corner[n % 5];
            b = corner[(n / 5) % 5];
            s = logic'(n / 25);
         end else begin
            a = $urandom;
            b = $urandom;
            s = logic'($urandom_range(1, 0));
         end
         ea = s ? {{32{a[31]}}, a} : {32'h0, a};
         eb = s ? {{32{b[31]}}, b} : {32'h0, b};
         expProd = ea * eb;
         run_mult(a, b, s, lat, pa, st);
         checks++; if (lat != 33 || st !== 1'b1) begin errors++; $display("[TB] FAIL rand_timing n=%0d got lat=%0d stable=%b expected lat=33 stable=1", n, lat, st); end
         checks++; if ({hi, lo} !== expProd) begin errors++; $display("[TB] FAIL rand_product n=%0d a=%h b=%h s=%b got %h_%h expected %h", n, a, b, s, hi, lo, expProd); end
         tick();
         checks++; if (done !== 1'b0 || {hi, lo} !== expProd) begin errors++; $display("[TB] FAIL rand_after n=%0d got done=%b %h_%h expected done=0 %h", n, done, hi, lo, expProd); end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      sgn   = 1'b0;
      srca  = '0;
      srcb  = '0;
      test_reset();
      test_multu_max();
      test_signed();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_regression();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
